// File: rtl/rsa_pkg.sv
// rsa_pkg: opcodes, FSM states and reset defaults shared by the RSA controller and its bench
package rsa_pkg;
  localparam logic [1:0] OP_ENC    = 2'b00;
  localparam logic [1:0] OP_LOAD_E = 2'b01;
  localparam logic [1:0] OP_LOAD_N = 2'b10;
  localparam int DATA_W    = 13;
  localparam int E_DEFAULT = 17;
  localparam int N_DEFAULT = 3233;
  localparam int N_MIN     = 256;
  typedef enum logic [3:0] {
    RSYNC_E, RSYNC_N, IDLE, LOAD_E, LOAD_N, INIT, STEP, FIN, CAPT, RESP
  } state_t;
endpackage

// File: rtl/rsa_controller_if.sv
// rsa_controller_if: command and result valid/ready handshakes of the RSA controller
interface rsa_controller_if #(parameter int DATA_W = rsa_pkg::DATA_W);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              result_valid;
  logic              result_ready;
  logic [15:0]       result_data;
  modport master (output cmd_valid, cmd_op, cmd_data, result_ready,
                  input  cmd_ready, result_valid, result_data);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, result_ready,
                  output cmd_ready, result_valid, result_data);
endinterface

// File: rtl/rsa_controller.sv
// rsa_controller: sequences the modular-exponentiation datapath for encrypt and key-load commands
module rsa_controller #(
  parameter int E_DEFAULT = rsa_pkg::E_DEFAULT,
  parameter int N_DEFAULT = rsa_pkg::N_DEFAULT,
  parameter int DATA_W    = rsa_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  rsa_controller_if.slave   bus,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_initialize,
  output logic              dp_en_multiply,
  output logic              dp_en_modulo,
  output logic              dp_done,
  output logic              dp_update_e,
  output logic              dp_update_n,
  input  logic              dp_mult_done,
  input  logic [15:0]       dp_output_data
);
  import rsa_pkg::*;
  state_t            state, nxt;
  logic [DATA_W-1:0] e_sh, n_sh;
  logic [15:0]       cnt;
  logic              acc, cap, step_go;
  assign acc = bus.cmd_valid & bus.cmd_ready;
  assign cap = cnt >= 16'(e_sh) - 16'd1;
  // the multiply pair depends on this cycle's done flag, so it is gated combinationally
  assign step_go = state == STEP && !dp_mult_done && !cap;
  assign dp_en_multiply = step_go;
  assign dp_en_modulo = dp_initialize | step_go;
  always_comb begin
    nxt = state;
    case (state)
      RSYNC_E: nxt = dp_update_e ? RSYNC_N : RSYNC_E;
      RSYNC_N, LOAD_E, LOAD_N: nxt = IDLE;
      IDLE: if (acc) nxt = bus.cmd_op == OP_ENC ? INIT :
                           bus.cmd_op == OP_LOAD_E && bus.cmd_data != '0 ? LOAD_E :
                           bus.cmd_op == OP_LOAD_N && bus.cmd_data >= DATA_W'(N_MIN) ? LOAD_N : IDLE;
      INIT: nxt = STEP;
      STEP: nxt = dp_mult_done ? FIN : cap ? IDLE : STEP;
      FIN:  nxt = CAPT;
      CAPT: nxt = RESP;
      RESP: nxt = bus.result_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= RSYNC_E;
      e_sh             <= DATA_W'(E_DEFAULT);
      n_sh             <= DATA_W'(N_DEFAULT);
      cnt              <= '0;
      bus.cmd_ready    <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_data  <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
      dp_data          <= '0;
      dp_initialize    <= 1'b0;
      dp_done          <= 1'b0;
      dp_update_e      <= 1'b0;
      dp_update_n      <= 1'b0;
    end else begin
      state            <= nxt;
      bus.cmd_ready    <= nxt == IDLE;
      busy             <= nxt != IDLE;
      err              <= (acc && nxt == IDLE) || (state == STEP && nxt == IDLE);
      dp_update_e      <= nxt == RSYNC_E || nxt == LOAD_E;
      dp_update_n      <= nxt == RSYNC_N || nxt == LOAD_N;
      dp_initialize    <= nxt == INIT;
      dp_done          <= nxt == FIN;
      bus.result_valid <= nxt == RESP;
      dp_data          <= nxt == RSYNC_E ? e_sh :
                          nxt == RSYNC_N ? n_sh :
                          nxt == INIT ? DATA_W'(bus.cmd_data[7:0]) :
                          (nxt == LOAD_E || nxt == LOAD_N) ? bus.cmd_data : '0;
      if (state == LOAD_E) e_sh <= dp_data;
      if (state == LOAD_N) n_sh <= dp_data;
      if (state == INIT) cnt <= '0;
      else if (step_go) cnt <= cnt + 16'd1;
      if (state == CAPT) bus.result_data <= dp_output_data;
    end
  end
endmodule
